// File: rtl/sparse_index_sequencer.sv
// Sparse index sequencer: streams N_IDX real indices interleaved with N_DUMMY
// LFSR-generated dummy indices over valid/ready, as directed by a slot mask.
module sparse_index_sequencer #(
   parameter int unsigned N_IDX   = 8,
   parameter int unsigned N_DUMMY = 8,
   parameter int unsigned IDX_W   = 15,
   parameter int unsigned POLY_N  = 17669
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       load_i,
   input  logic [16*N_IDX-1:0]        idx_pack_i,
   input  logic [15:0]                seed_i,
   input  logic [N_IDX+N_DUMMY-1:0]   mask_i,
   output logic [IDX_W-1:0]           idx_o,
   output logic                       dummy_o,
   output logic                       last_o,
   output logic                       valid_o,
   input  logic                       ready_i,
   output logic                       busy_o,
   output logic                       done_o,
   output logic                       err_o
);

   localparam int unsigned S      = N_IDX + N_DUMMY;
   localparam int unsigned SLOT_W = $clog2(S);
   localparam int unsigned CNT_W  = $clog2(S + 1);
   localparam int unsigned PACK_W = N_IDX * IDX_W;
   localparam int unsigned HI_W   = N_IDX * (16 - IDX_W);

   typedef enum logic {ST_IDLE, ST_RUN} state_t;

   state_t              r_state;
   logic [SLOT_W-1:0]   r_slot;
   logic [CNT_W-1:0]    r_rc;
   logic [CNT_W-1:0]    r_dc;
   logic [15:0]         r_lfsr;
   logic [S-1:0]        r_mask;
   logic [PACK_W-1:0]   r_pack;
   logic [IDX_W-1:0]    r_idx;
   logic                r_dummy;
   logic                r_last;
   logic                r_valid;
   logic                r_busy;
   logic                r_done;
   logic                r_err;

   logic [PACK_W-1:0]   w_in_pack;
   logic [HI_W-1:0]     w_pack_hi;
   logic                w_err_in;
   logic [SLOT_W-1:0]   w_sel_slot;
   logic [CNT_W-1:0]    w_sel_rc;
   logic [CNT_W-1:0]    w_sel_dc;
   logic [15:0]         w_sel_lfsr;
   logic [S-1:0]        w_sel_mask;
   logic [PACK_W-1:0]   w_sel_pack;
   logic [IDX_W-1:0]    w_field;
   logic                w_nx_dummy;
   logic [IDX_W-1:0]    w_nx_idx;
   logic                w_nx_last;
   logic                w_unused;

   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      lfsr_step = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
   endfunction

   // Single conditional subtract suffices because POLY_N > 2^(IDX_W-1).
   function automatic logic [IDX_W-1:0] fold(input logic [15:0] l);
      logic [IDX_W-1:0] d;
      d    = l[IDX_W-1:0];
      fold = (d >= IDX_W'(POLY_N)) ? d - IDX_W'(POLY_N) : d;
   endfunction

   // Next token: slot 0 from the load inputs in IDLE, else the slot after the current one.
   always_comb begin
      w_in_pack = '0;
      w_pack_hi = '0;
      w_err_in  = 1'b0;
      for (int k = 0; k < int'(N_IDX); k++) begin
         w_in_pack[k*IDX_W +: IDX_W]         = idx_pack_i[k*16 +: IDX_W];
         w_pack_hi[k*(16-IDX_W) +: 16-IDX_W] = idx_pack_i[k*16+IDX_W +: 16-IDX_W];
         if (idx_pack_i[k*16 +: IDX_W] >= IDX_W'(POLY_N)) w_err_in = 1'b1;
      end

      if (r_state == ST_IDLE) begin
         w_sel_slot = '0;
         w_sel_rc   = '0;
         w_sel_dc   = '0;
         w_sel_lfsr = (seed_i == 16'h0000) ? 16'hACE1 : seed_i;
         w_sel_mask = mask_i;
         w_sel_pack = w_in_pack;
      end else begin
         w_sel_slot = r_slot + SLOT_W'(1);
         w_sel_rc   = r_rc;
         w_sel_dc   = r_dc;
         w_sel_lfsr = r_dummy ? lfsr_step(r_lfsr) : r_lfsr;
         w_sel_mask = r_mask;
         w_sel_pack = r_pack;
      end

      w_field = '0;
      for (int k = 0; k < int'(N_IDX); k++) begin
         if (w_sel_rc == CNT_W'(k)) w_field = w_sel_pack[k*IDX_W +: IDX_W];
      end

      w_nx_dummy = (w_sel_mask[w_sel_slot] && (w_sel_dc < CNT_W'(N_DUMMY)))
                   || (w_sel_rc == CNT_W'(N_IDX));
      w_nx_idx   = w_nx_dummy ? fold(w_sel_lfsr) : w_field;
      w_nx_last  = (w_sel_slot == SLOT_W'(S - 1));
   end

   assign w_unused = ^{1'b0, w_pack_hi};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_slot  <= '0;
         r_rc    <= '0;
         r_dc    <= '0;
         r_lfsr  <= 16'hACE1;
         r_mask  <= '0;
         r_pack  <= '0;
         r_idx   <= '0;
         r_dummy <= 1'b0;
         r_last  <= 1'b0;
         r_valid <= 1'b0;
         r_busy  <= 1'b0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (load_i) begin
                  r_state <= ST_RUN;
                  r_mask  <= mask_i;
                  r_pack  <= w_in_pack;
                  r_err   <= w_err_in;
                  r_slot  <= w_sel_slot;
                  r_lfsr  <= w_sel_lfsr;
                  r_rc    <= w_sel_rc + CNT_W'(!w_nx_dummy);
                  r_dc    <= w_sel_dc + CNT_W'(w_nx_dummy);
                  r_idx   <= w_nx_idx;
                  r_dummy <= w_nx_dummy;
                  r_last  <= w_nx_last;
                  r_valid <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (r_valid && ready_i) begin
                  r_lfsr <= w_sel_lfsr;
                  if (r_last) begin
                     r_state <= ST_IDLE;
                     r_idx   <= '0;
                     r_dummy <= 1'b0;
                     r_last  <= 1'b0;
                     r_valid <= 1'b0;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end else begin
                     r_slot  <= w_sel_slot;
                     r_rc    <= w_sel_rc + CNT_W'(!w_nx_dummy);
                     r_dc    <= w_sel_dc + CNT_W'(w_nx_dummy);
                     r_idx   <= w_nx_idx;
                     r_dummy <= w_nx_dummy;
                     r_last  <= w_nx_last;
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign idx_o   = r_idx;
   assign dummy_o = r_dummy;
   assign last_o  = r_last;
   assign valid_o = r_valid;
   assign busy_o  = r_busy;
   assign done_o  = r_done;
   assign err_o   = r_err;

endmodule
